// File: rtl/axo_peri_arbiter_if.sv
// Peripheral bus shared by requesters and the target: MEM is the target side
// (what the arbiter presents to each requester), CPU is the initiator side.
interface axo_peri_bus #(
  parameter int alen = 12
);
  logic            re;
  logic            we;
  logic [alen-1:0] addr;
  logic [31:0]     wdata;
  logic            ready;
  logic [31:0]     rdata;

  modport MEM (input re, we, addr, wdata, output ready, rdata);
  modport CPU (output re, we, addr, wdata, input ready, rdata);
endinterface

// File: rtl/axo_peri_arbiter.sv
// Round-robin arbiter sharing one peripheral bus among reqs requesters.
// Define AXO_PERI_ARB_TIMEOUT_EN to add a BUSY-state watchdog.
module axo_peri_arbiter #(
  parameter int alen    = 12,
  parameter int reqs    = 2,
  parameter int timeout = 255
) (
  input  logic            clk,
  input  logic            rst,
  axo_peri_bus.MEM        req_ports [reqs],
  axo_peri_bus.CPU        mem_port,
  output logic [reqs-1:0] grant
);

  localparam int PW = (reqs > 1) ? $clog2(reqs) : 1;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state;
  logic [PW-1:0]   ptr;
  logic [PW-1:0]   owner;
  logic [PW-1:0]   win;
  logic            found;
  logic            owner_pend;
  logic            timeout_hit;
  logic [PW-1:0]   owner_next;

  logic [reqs-1:0] req_re;
  logic [reqs-1:0] req_we;
  logic [alen-1:0] req_addr  [reqs];
  logic [31:0]     req_wdata [reqs];

  // Flatten the interface array so the owner can be selected by a variable index.
  for (genvar g = 0; g < reqs; g++) begin : g_port
    assign req_re[g]    = req_ports[g].re;
    assign req_we[g]    = req_ports[g].we;
    assign req_addr[g]  = req_ports[g].addr;
    assign req_wdata[g] = req_ports[g].wdata;

    assign req_ports[g].ready = (state == BUSY) && (owner == PW'(g)) && owner_pend &&
                                (timeout_hit || mem_port.ready);
    assign req_ports[g].rdata = ((state == BUSY) && (owner == PW'(g))) ?
                                (timeout_hit ? 32'hFFFF_FFFF : mem_port.rdata) : 32'h0;
  end

  assign owner_pend = req_re[owner] | req_we[owner];
  assign owner_next = (owner == PW'(reqs - 1)) ? '0 : owner + 1'b1;

  // First pending requester at or after ptr, wrapping modulo reqs.
  always_comb begin
    int idx;
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int k = 0; k < reqs; k++) begin
      idx = (int'(ptr) + k) % reqs;
      if (!found && (req_re[idx] || req_we[idx])) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  always_comb begin
    mem_port.re    = 1'b0;
    mem_port.we    = 1'b0;
    mem_port.addr  = '0;
    mem_port.wdata = '0;
    if (state == BUSY) begin
      mem_port.re    = req_re[owner] & ~timeout_hit;
      mem_port.we    = req_we[owner] & ~timeout_hit;
      mem_port.addr  = req_addr[owner];
      mem_port.wdata = req_wdata[owner];
    end
  end

`ifdef AXO_PERI_ARB_TIMEOUT_EN
  logic [15:0] wd_cnt;

  assign timeout_hit = (state == BUSY) && (wd_cnt == 16'(timeout));

  always_ff @(posedge clk) begin
    if (!rst || state == IDLE) begin
      wd_cnt <= '0;
    end else if (!mem_port.ready) begin
      wd_cnt <= wd_cnt + 16'd1;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      ptr   <= '0;
      owner <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            state <= BUSY;
            owner <= win;
            grant <= {{(reqs-1){1'b0}}, 1'b1} << win;
          end
        end
        BUSY: begin
          // Completion, abort and watchdog expiry all release the bus the same way.
          if (!owner_pend || mem_port.ready || timeout_hit) begin
            state <= IDLE;
            grant <= '0;
            ptr   <= owner_next;
          end
        end
        default: begin
          state <= IDLE;
          grant <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axo_peri_arbiter.sv
// Directed bench for axo_peri_arbiter with two requesters and timeout = 4.
module tb_axo_peri_arbiter;

  logic       clk;
  logic       rst;
  logic [1:0] grant;
  int         tests;
  int         fails;

  axo_peri_bus #(.alen(12)) req_bus [2] ();
  axo_peri_bus #(.alen(12)) mem_bus ();

  axo_peri_arbiter #(.alen(12), .reqs(2), .timeout(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_ports (req_bus),
    .mem_port  (mem_bus),
    .grant     (grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    req_bus[0].re = 1'b0; req_bus[0].we = 1'b0; req_bus[0].addr = '0; req_bus[0].wdata = '0;
    req_bus[1].re = 1'b0; req_bus[1].we = 1'b0; req_bus[1].addr = '0; req_bus[1].wdata = '0;
    mem_bus.ready = 1'b0;
    mem_bus.rdata = '0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    clear_inputs();
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL reset_grant: got %b expected %b", grant, 2'b00); end
    tests++; if (mem_bus.re !== 1'b0 || mem_bus.we !== 1'b0) begin fails++; $display("[TB] FAIL reset_mem_rw: got re=%b we=%b expected 0 0", mem_bus.re, mem_bus.we); end
    tests++; if (req_bus[0].ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready0: got %b expected 0", req_bus[0].ready); end
  endtask

  task automatic test_single_read();
    do_reset();
    req_bus[0].re = 1'b1; req_bus[0].addr = 12'h004;
    mem_bus.ready = 1'b1; mem_bus.rdata = 32'hDEADBEEF;
    #1;
    tests++; if (req_bus[0].ready !== 1'b0) begin fails++; $display("[TB] FAIL read_idle_ready: got %b expected 0", req_bus[0].ready); end
    tests++; if (mem_bus.re !== 1'b0) begin fails++; $display("[TB] FAIL read_idle_mem_re: got %b expected 0", mem_bus.re); end
    tick();
    tests++; if (grant !== 2'b01) begin fails++; $display("[TB] FAIL read_grant: got %b expected %b", grant, 2'b01); end
    tests++; if (mem_bus.re !== 1'b1 || mem_bus.addr !== 12'h004) begin fails++; $display("[TB] FAIL read_fwd: got re=%b addr=%h expected 1 004", mem_bus.re, mem_bus.addr); end
    tests++; if (req_bus[0].ready !== 1'b1) begin fails++; $display("[TB] FAIL read_ready: got %b expected 1", req_bus[0].ready); end
    tests++; if (req_bus[0].rdata !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL read_rdata: got %h expected %h", req_bus[0].rdata, 32'hDEADBEEF); end
    tests++; if (req_bus[1].rdata !== 32'h0) begin fails++; $display("[TB] FAIL read_other_rdata: got %h expected 0", req_bus[1].rdata); end
    tick();
    req_bus[0].re = 1'b0;
    #1;
    tests++; if (grant !== 2'b00 || mem_bus.re !== 1'b0) begin fails++; $display("[TB] FAIL read_done_idle: got grant=%b re=%b expected 00 0", grant, mem_bus.re); end
  endtask

  task automatic test_round_robin();
    logic [1:0] exp_grant [4];
    exp_grant[0] = 2'b01; exp_grant[1] = 2'b10; exp_grant[2] = 2'b01; exp_grant[3] = 2'b10;
    do_reset();
    req_bus[0].re = 1'b1; req_bus[0].addr = 12'h010;
    req_bus[1].re = 1'b1; req_bus[1].addr = 12'h020;
    mem_bus.ready = 1'b1; mem_bus.rdata = 32'h1234_5678;
    for (int t = 0; t < 4; t++) begin
      tick();
      tests++; if (grant !== exp_grant[t]) begin fails++; $display("[TB] FAIL rr_grant%0d: got %b expected %b", t, grant, exp_grant[t]); end
      if (exp_grant[t] == 2'b01) begin
        tests++; if (req_bus[1].ready !== 1'b0 || req_bus[1].rdata !== 32'h0) begin fails++; $display("[TB] FAIL rr_nonowner%0d: got ready=%b rdata=%h expected 0 0", t, req_bus[1].ready, req_bus[1].rdata); end
        tests++; if (mem_bus.addr !== 12'h010) begin fails++; $display("[TB] FAIL rr_addr%0d: got %h expected 010", t, mem_bus.addr); end
      end else begin
        tests++; if (req_bus[0].ready !== 1'b0 || req_bus[0].rdata !== 32'h0) begin fails++; $display("[TB] FAIL rr_nonowner%0d: got ready=%b rdata=%h expected 0 0", t, req_bus[0].ready, req_bus[0].rdata); end
        tests++; if (mem_bus.addr !== 12'h020) begin fails++; $display("[TB] FAIL rr_addr%0d: got %h expected 020", t, mem_bus.addr); end
      end
      tick();
      tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL rr_gap%0d: got %b expected 00", t, grant); end
    end
    clear_inputs();
  endtask

  task automatic test_wait_write();
    do_reset();
    req_bus[1].we = 1'b1; req_bus[1].wdata = 32'h5A;
    mem_bus.ready = 1'b0;
    tick();
    tests++; if (grant !== 2'b10) begin fails++; $display("[TB] FAIL wr_grant: got %b expected 10", grant); end
    for (int c = 1; c <= 4; c++) begin
      if (c == 4) begin
        mem_bus.ready = 1'b1;
        #1;
      end
      tests++; if (mem_bus.we !== 1'b1 || mem_bus.wdata !== 32'h5A) begin fails++; $display("[TB] FAIL wr_fwd%0d: got we=%b wdata=%h expected 1 0000005a", c, mem_bus.we, mem_bus.wdata); end
      tests++; if (req_bus[1].ready !== (c == 4)) begin fails++; $display("[TB] FAIL wr_ready%0d: got %b expected %b", c, req_bus[1].ready, (c == 4)); end
      tick();
    end
    tests++; if (mem_bus.we !== 1'b0 || grant !== 2'b00) begin fails++; $display("[TB] FAIL wr_after: got we=%b grant=%b expected 0 00", mem_bus.we, grant); end
    clear_inputs();
  endtask

  task automatic test_abort();
    do_reset();
    req_bus[0].re = 1'b1;
    tick();
    tests++; if (grant !== 2'b01) begin fails++; $display("[TB] FAIL abort_grant: got %b expected 01", grant); end
    tick();
    req_bus[0].re = 1'b0;
    #1;
    tests++; if (req_bus[0].ready !== 1'b0 || mem_bus.re !== 1'b0) begin fails++; $display("[TB] FAIL abort_drop: got ready=%b re=%b expected 0 0", req_bus[0].ready, mem_bus.re); end
    tick();
    tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL abort_idle: got %b expected 00", grant); end
    req_bus[0].re = 1'b1; req_bus[1].re = 1'b1;
    tick();
    tests++; if (grant !== 2'b10) begin fails++; $display("[TB] FAIL abort_ptr: got %b expected 10", grant); end
    clear_inputs();
    tick();
    tick();
  endtask

  task automatic test_reset_mid_busy();
    do_reset();
    req_bus[0].re = 1'b1; mem_bus.ready = 1'b1;
    tick();
    tick();
    req_bus[0].re = 1'b0; mem_bus.ready = 1'b0;
    req_bus[1].re = 1'b1;
    tick();
    tests++; if (grant !== 2'b10) begin fails++; $display("[TB] FAIL rstb_grant: got %b expected 10", grant); end
    rst = 1'b0;
    req_bus[0].re = 1'b1;
    tick();
    tests++; if (grant !== 2'b00 || mem_bus.re !== 1'b0 || mem_bus.we !== 1'b0) begin fails++; $display("[TB] FAIL rstb_clear: got grant=%b re=%b we=%b expected 00 0 0", grant, mem_bus.re, mem_bus.we); end
    tests++; if (req_bus[1].ready !== 1'b0) begin fails++; $display("[TB] FAIL rstb_noready: got %b expected 0", req_bus[1].ready); end
    rst = 1'b1;
    tick();
    tests++; if (grant !== 2'b01) begin fails++; $display("[TB] FAIL rstb_first: got %b expected 01", grant); end
    clear_inputs();
  endtask

  task automatic test_timeout();
    do_reset();
    req_bus[0].re = 1'b1; mem_bus.rdata = 32'h0000_1234;
    tick();
    for (int c = 1; c <= 4; c++) begin
      tests++; if (req_bus[0].ready !== 1'b0 || mem_bus.re !== 1'b1) begin fails++; $display("[TB] FAIL to_wait%0d: got ready=%b re=%b expected 0 1", c, req_bus[0].ready, mem_bus.re); end
      tick();
    end
`ifdef AXO_PERI_ARB_TIMEOUT_EN
    tests++; if (req_bus[0].ready !== 1'b1 || req_bus[0].rdata !== 32'hFFFF_FFFF) begin fails++; $display("[TB] FAIL to_fire: got ready=%b rdata=%h expected 1 ffffffff", req_bus[0].ready, req_bus[0].rdata); end
    tests++; if (mem_bus.re !== 1'b0) begin fails++; $display("[TB] FAIL to_force: got %b expected 0", mem_bus.re); end
    tick();
    tests++; if (grant !== 2'b00) begin fails++; $display("[TB] FAIL to_idle: got %b expected 00", grant); end
`else
    tests++; if (req_bus[0].ready !== 1'b0 || req_bus[0].rdata !== 32'h0000_1234) begin fails++; $display("[TB] FAIL to_stall: got ready=%b rdata=%h expected 0 00001234", req_bus[0].ready, req_bus[0].rdata); end
    tick();
    tests++; if (grant !== 2'b01 || mem_bus.re !== 1'b1) begin fails++; $display("[TB] FAIL to_hold: got grant=%b re=%b expected 01 1", grant, mem_bus.re); end
`endif
    clear_inputs();
    tick();
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst   = 1'b0;
    clear_inputs();
    test_reset();
    test_single_read();
    test_round_robin();
    test_wait_write();
    test_abort();
    test_reset_mid_busy();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
